bf16_block_gather: RTL

Upstream feeder for `conv_bf16tomxi8`. It accepts a narrow valid/ready stream of bf16 values, `lanes` per beat, and assembles them into `k`-element blocks. Each completed block is presented as one full-width vector plus a valid flag, ready to drive the converter's `i_bf16_vec`. A partial block, closed early by `i_last`, is zero-padded so that MX scaling always sees exactly `k` elements.

---
 rtl/mx_pkg.sv | 17 +
 rtl/bf16_block_gather.sv | 115 +++++++++++
 2 files changed

// File: rtl/mx_pkg.sv
// Shared bf16/MX definitions used by the block gatherer and the bf16->mxi8 converter.
package mx_pkg;

  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_ZERO = 16'h0000;

  typedef enum logic {
    GATHER_FILL = 1'b0,
    GATHER_HOLD = 1'b1
  } gather_state_t;

  function automatic int beats_of(input int k, input int lanes);
    return k / lanes;
  endfunction

endpackage

// File: rtl/bf16_block_gather.sv
// Collects a narrow bf16 beat stream into k-element blocks for the MX converter;
// blocks closed early by i_last are zero-padded to the full k elements.
module bf16_block_gather
  import mx_pkg::*;
#(
  parameter int k     = 32,
  parameter int lanes = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  bf16_t [lanes-1:0]        i_bf16,
  input  logic                     i_last,
  output logic                     o_vec_valid,
  input  logic                     i_vec_ready,
  output bf16_t [k-1:0]            o_bf16_vec,
  output logic [$clog2(k+1)-1:0]   o_vec_len
);

  localparam int BEATS = beats_of(k, lanes);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = $clog2(k + 1);

  if (lanes < 1 || (k % lanes) != 0) begin : g_bad_cfg
    $error("bf16_block_gather: lanes must be >= 1 and divide k");
  end

  gather_state_t   state;
  logic [CW-1:0]   count;
  logic [LW-1:0]   hold_len;
  bf16_t [k-1:0]   asm_buf;

  logic            accept;
  logic            last_beat;
  logic            complete;
  logic            out_free;
  logic [LW-1:0]   blk_len;
  bf16_t [k-1:0]   merged;
  bf16_t [k-1:0]   padded;

  // Incoming beat merged into the buffer, and the padded view used on completion
  always_comb begin
    accept    = i_valid && o_ready;
    last_beat = (count == CW'(BEATS - 1));
    complete  = accept && (last_beat || i_last);
    out_free  = !o_vec_valid || i_vec_ready;
    blk_len   = LW'((int'(count) + 1) * lanes);
    merged    = asm_buf;
    padded    = '0;
    for (int i = 0; i < k; i++) begin
      if (accept && ((i / lanes) == int'(count))) begin
        merged[i] = i_bf16[i % lanes];
      end
      padded[i] = (i < int'(blk_len)) ? merged[i] : BF16_ZERO;
    end
  end

  // Assembly buffer: a held block is stored already padded
  always_ff @(posedge i_clk) begin
    if (accept) begin
      asm_buf <= complete ? padded : merged;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= GATHER_FILL;
      count       <= '0;
      o_ready     <= 1'b0;
      o_vec_valid <= 1'b0;
      o_bf16_vec  <= '0;
      o_vec_len   <= '0;
    end else begin
      case (state)
        GATHER_FILL: begin
          o_ready <= 1'b1;
          if (complete) begin
            count <= '0;
            if (out_free) begin
              o_vec_valid <= 1'b1;
              o_bf16_vec  <= padded;
              o_vec_len   <= blk_len;
            end else begin
              state    <= GATHER_HOLD;
              hold_len <= blk_len;
              o_ready  <= 1'b0;
            end
          end else begin
            if (accept) begin
              count <= count + CW'(1);
            end
            if (i_vec_ready) begin
              o_vec_valid <= 1'b0;
            end
          end
        end
        GATHER_HOLD: begin
          if (out_free) begin
            state       <= GATHER_FILL;
            o_ready     <= 1'b1;
            o_vec_valid <= 1'b1;
            o_bf16_vec  <= asm_buf;
            o_vec_len   <= hold_len;
          end
        end
        default: begin
          state   <= GATHER_FILL;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
